// File: rtl/gmii_tx_arbiter.sv
`timescale 1ns/1ps
// Two-source round-robin GMII TX scheduler: preamble/SFD insertion, payload streaming and IFG.
// Defining GMII_TX_FCS_EN appends a CRC-32 FCS after the payload.
module gmii_tx_arbiter #(
    parameter int unsigned PRE_BYTES = 7,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic       ch0_req,
    input  logic [7:0] ch0_data,
    input  logic       ch0_last,
    output logic       ch0_rd,
    input  logic       ch1_req,
    input  logic [7:0] ch1_data,
    input  logic       ch1_last,
    output logic       ch1_rd,
    output logic [1:0] grant,
    output logic       busy,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer
);

`ifdef GMII_TX_FCS_EN
    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StFcs, StIfg} state_e;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    logic [31:0] crc_q, crc_d;
`else
    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StIfg} state_e;
`endif

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_served_q, last_served_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        txer_q, txer_d;

    logic        sel_req, sel_last, rd_en, pick;
    logic [7:0]  sel_data;

    assign sel_req  = owner_q ? ch1_req  : ch0_req;
    assign sel_last = owner_q ? ch1_last : ch0_last;
    assign sel_data = owner_q ? ch1_data : ch0_data;
    assign rd_en    = (state_q == StData) && sel_req;
    assign ch0_rd   = rd_en && !owner_q;
    assign ch1_rd   = rd_en && owner_q;
    assign pick     = (ch0_req && ch1_req) ? !last_served_q : ch1_req;

    assign grant     = grant_q;
    assign busy      = (state_q != StIdle);
    assign gmii_txd  = txd_q;
    assign gmii_txen = txen_q;
    assign gmii_txer = txer_q;

    // Each state decides what the output registers load at the coming edge,
    // so the wire shows that state's byte one cycle later.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        grant_d       = grant_q;
        txd_d         = 8'h00;
        txen_d        = 1'b0;
        txer_d        = 1'b0;
`ifdef GMII_TX_FCS_EN
        crc_d         = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                grant_d = 2'b00;
                if (ch0_req || ch1_req) begin
                    owner_d = pick;
                    grant_d = pick ? 2'b10 : 2'b01;
                    txd_d   = 8'h55;
                    txen_d  = 1'b1;
                    if (PRE_BYTES > 1) begin
                        state_d = StPre;
                        cnt_d   = 4'(PRE_BYTES - 1);
                    end else begin
                        state_d = StSfd;
                    end
                end
            end
            StPre: begin
                txd_d  = 8'h55;
                txen_d = 1'b1;
                if (cnt_q <= 4'd1) state_d = StSfd;
            end
            StSfd: begin
                txd_d   = 8'hD5;
                txen_d  = 1'b1;
                state_d = StData;
`ifdef GMII_TX_FCS_EN
                crc_d   = '1;
`endif
            end
            StData: begin
                txen_d = 1'b1;
                if (sel_req) begin
                    txd_d = sel_data;
`ifdef GMII_TX_FCS_EN
                    crc_d = crc_byte(crc_q, sel_data);
`endif
                    if (sel_last) begin
                        last_served_d = owner_q;
`ifdef GMII_TX_FCS_EN
                        state_d = StFcs;
                        cnt_d   = 4'd4;
`else
                        state_d = StIfg;
                        cnt_d   = 4'(IFG_BYTES);
`endif
                    end
                end else begin
                    // Source ran dry before its last byte: poison the frame.
                    txer_d        = 1'b1;
                    last_served_d = owner_q;
                    state_d       = StIfg;
                    cnt_d         = 4'(IFG_BYTES);
                end
            end
`ifdef GMII_TX_FCS_EN
            StFcs: begin
                txd_d  = ~crc_q[7:0];
                txen_d = 1'b1;
                crc_d  = crc_q >> 8;
                if (cnt_q <= 4'd1) begin
                    state_d = StIfg;
                    cnt_d   = 4'(IFG_BYTES);
                end
            end
`endif
            StIfg: begin
                grant_d = 2'b00;
                if (cnt_q <= 4'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            owner_q       <= 1'b0;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
            txd_q         <= 8'h00;
            txen_q        <= 1'b0;
            txer_q        <= 1'b0;
`ifdef GMII_TX_FCS_EN
            crc_q         <= '1;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            grant_q       <= grant_d;
            txd_q         <= txd_d;
            txen_q        <= txen_d;
            txer_q        <= txer_d;
`ifdef GMII_TX_FCS_EN
            crc_q         <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for gmii_tx_arbiter: stimulus pushes expected wire bytes, a monitor pops them.
module tb_gmii_tx_arbiter;

    localparam int IfgBytes = 12;
`ifdef GMII_TX_FCS_EN
    localparam bit FcsOn = 1'b1;
`else
    localparam bit FcsOn = 1'b0;
`endif

    typedef struct {
        logic [7:0] txd;
        logic       txer;
        logic [1:0] grant;
        int         gap;
    } exp_t;

    logic       gmii_tx_clk;
    logic       rst_n;
    logic       ch0_req, ch0_last, ch0_rd, ch1_req, ch1_last, ch1_rd;
    logic [7:0] ch0_data, ch1_data;
    logic [1:0] grant;
    logic       busy, gmii_txen, gmii_txer;
    logic [7:0] gmii_txd;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt0 = 0;
    int         rd_cnt1 = 0;

    logic [7:0] src_mem[2][16];
    int         src_len[2];
    int         src_cut[2];
    int         src_idx[2];
    bit         src_act[2];

    gmii_tx_arbiter #(.PRE_BYTES(7), .IFG_BYTES(IfgBytes)) dut (
        .gmii_tx_clk (gmii_tx_clk),
        .rst_n       (rst_n),
        .ch0_req     (ch0_req),
        .ch0_data    (ch0_data),
        .ch0_last    (ch0_last),
        .ch0_rd      (ch0_rd),
        .ch1_req     (ch1_req),
        .ch1_data    (ch1_data),
        .ch1_last    (ch1_last),
        .ch1_rd      (ch1_rd),
        .grant       (grant),
        .busy        (busy),
        .gmii_txd    (gmii_txd),
        .gmii_txen   (gmii_txen),
        .gmii_txer   (gmii_txer)
    );

    initial begin
        gmii_tx_clk = 1'b0;
        forever #4 gmii_tx_clk = ~gmii_tx_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        logic [1:0] req_v;
        logic [7:0] d_v[2];
        logic [1:0] last_v;
        for (int c = 0; c < 2; c++) begin
            req_v[c]  = src_act[c] && (src_idx[c] < src_len[c]) &&
                        (src_cut[c] < 0 || src_idx[c] < src_cut[c]);
            d_v[c]    = (req_v[c] && src_idx[c] < 16) ? src_mem[c][src_idx[c]] : 8'h00;
            last_v[c] = req_v[c] && (src_idx[c] == src_len[c] - 1);
        end
        ch0_req = req_v[0]; ch0_data = d_v[0]; ch0_last = last_v[0];
        ch1_req = req_v[1]; ch1_data = d_v[1]; ch1_last = last_v[1];
    endtask

    task automatic fill(input int ch, input logic [7:0] base, input int len, input int cut);
        for (int i = 0; i < len; i++) src_mem[ch][i] = base + 8'(i);
        src_len[ch] = len;
        src_cut[ch] = cut;
    endtask

    task automatic arm(input int ch);
        src_idx[ch] = 0;
        src_act[ch] = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic er, input logic [1:0] g, input int gap);
        exp_t e;
        e.txd = d; e.txer = er; e.grant = g; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // gap: -1 = at least IfgBytes idle before this frame, >=0 = exactly that many, -2 = unchecked.
    task automatic exp_frame(input int ch, input int gap, input bit fcs);
        logic [1:0]  g;
        logic [31:0] c;
        int          n;
        g = (ch == 1) ? 2'b10 : 2'b01;
        for (int i = 0; i < 7; i++) push(8'h55, 1'b0, g, (i == 0) ? gap : -2);
        push(8'hD5, 1'b0, g, -2);
        n = (src_cut[ch] >= 0) ? src_cut[ch] : src_len[ch];
        for (int i = 0; i < n; i++) push(src_mem[ch][i], 1'b0, g, -2);
        if (src_cut[ch] >= 0) begin
            push(8'h00, 1'b1, g, -2);
        end else if (fcs && FcsOn) begin
            c = 32'hFFFF_FFFF;
            for (int i = 0; i < src_len[ch]; i++) begin
                c = c ^ {24'h0, src_mem[ch][i]};
                for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
            c = ~c;
            for (int i = 0; i < 4; i++) push(c[8*i +: 8], 1'b0, g, -2);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge gmii_tx_clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL idle timeout: %0d bytes still expected, busy=%0d", exp_q.size(), busy);
        end
        repeat (2) @(negedge gmii_tx_clk);
    endtask

    task automatic at_drive_slot();
        @(posedge gmii_tx_clk);
        #2;
    endtask

    // Source model: FWFT, advances one byte per rd seen in the preceding cycle.
    initial begin
        logic [1:0] rd_s;
        forever begin
            @(negedge gmii_tx_clk);
            rd_s = {ch1_rd, ch0_rd};
            @(posedge gmii_tx_clk);
            #1;
            for (int c = 0; c < 2; c++) if (rd_s[c]) src_idx[c]++;
            drive_src();
        end
    end

    // Monitor: pops one expected byte per txen cycle and checks the gap before each frame.
    initial begin
        exp_t e;
        bit   in_frame;
        bit   seen_frame;
        int   idle_run;
        in_frame = 0; seen_frame = 0; idle_run = 0;
        forever begin
            @(negedge gmii_tx_clk);
            if (!rst_n) begin
                in_frame = 0; seen_frame = 0; idle_run = 0;
            end else begin
                check("rd exclusive", {31'd0, ch0_rd & ch1_rd}, 32'd0);
                rd_cnt0 += int'(ch0_rd);
                rd_cnt1 += int'(ch1_rd);
                if (gmii_txen) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wire: unexpected byte %h txer=%0d, none expected at %0t",
                                 gmii_txd, gmii_txer, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (!in_frame && seen_frame) begin
                            if (e.gap == -1)
                                check("gap min", (idle_run >= IfgBytes) ? 32'd1 : 32'd0, 32'd1);
                            else if (e.gap >= 0)
                                check("gap exact", 32'(idle_run), 32'(e.gap));
                        end
                        check("wire {txer,txd,grant}", 32'({gmii_txer, gmii_txd, grant}),
                              32'({e.txer, e.txd, e.grant}));
                    end
                    in_frame = 1;
                    idle_run = 0;
                end else begin
                    if (in_frame) seen_frame = 1;
                    in_frame = 0;
                    idle_run++;
                    check("idle {txer,grant}", 32'({gmii_txer, grant}), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        src_act[0] = 0; src_act[1] = 0;
        src_idx[0] = 0; src_idx[1] = 0;
        src_len[0] = 0; src_len[1] = 0;
        src_cut[0] = -1; src_cut[1] = -1;
        drive_src();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset outputs {txen,txer,txd,grant,busy,rd}",
              32'({gmii_txen, gmii_txer, gmii_txd, grant, busy, ch0_rd, ch1_rd}), 32'd0);
        repeat (3) @(posedge gmii_tx_clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge gmii_tx_clk);

        // Simultaneous requests after reset: ch0 first, ch1 after exactly one IFG.
        at_drive_slot();
        fill(0, 8'hA0, 3, -1);
        fill(1, 8'hB0, 3, -1);
        exp_frame(0, -1, 1);
        exp_frame(1, IfgBytes, 1);
        arm(0); arm(1); drive_src();
        wait_idle();

        // Lone ch0 frame {11,22,33,44}.
        rd_cnt0 = 0;
        at_drive_slot();
        fill(0, 8'h11, 4, -1);
        for (int i = 0; i < 4; i++) src_mem[0][i] = 8'(17 * (i + 1));
        exp_frame(0, -1, 1);
        arm(0); drive_src();
        wait_idle();
        check("ch0 rd count, 4-byte frame", 32'(rd_cnt0), 32'd4);

        // ch0 was served last: the next simultaneous request goes to ch1 first.
        at_drive_slot();
        fill(0, 8'hC0, 3, -1);
        fill(1, 8'hD0, 4, -1);
        exp_frame(1, -1, 1);
        exp_frame(0, IfgBytes, 1);
        arm(0); arm(1); drive_src();
        wait_idle();

        // ch1 "123456789": FCS bytes 26 39 F4 CB when enabled.
        rd_cnt1 = 0;
        at_drive_slot();
        fill(1, 8'h31, 9, -1);
        exp_frame(1, -1, 0);
        if (FcsOn) begin
            push(8'h26, 1'b0, 2'b10, -2);
            push(8'h39, 1'b0, 2'b10, -2);
            push(8'hF4, 1'b0, 2'b10, -2);
            push(8'hCB, 1'b0, 2'b10, -2);
        end
        arm(1); drive_src();
        wait_idle();
        check("ch1 rd count, 9-byte frame", 32'(rd_cnt1), 32'd9);

        // Underrun after 2 of 5 bytes, then ch1 request in the third gap cycle.
        rd_cnt0 = 0;
        rd_cnt1 = 0;
        at_drive_slot();
        fill(0, 8'hE0, 5, 2);
        exp_frame(0, -1, 1);
        arm(0); drive_src();
        n = 0;
        while (!gmii_txer && n < 100) begin
            @(negedge gmii_tx_clk);
            n++;
        end
        check("txer seen before timeout", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(posedge gmii_tx_clk);
        at_drive_slot();
        fill(1, 8'hF0, 3, -1);
        exp_frame(1, IfgBytes, 1);
        arm(1); drive_src();
        wait_idle();
        check("ch0 rd count, underrun", 32'(rd_cnt0), 32'd2);
        check("ch1 rd count, after gap", 32'(rd_cnt1), 32'd3);

        // Reset in the middle of DATA, then a fresh preamble for the still-pending request.
        at_drive_slot();
        fill(0, 8'h60, 8, -1);
        exp_frame(0, -1, 1);
        arm(0); drive_src();
        n = 0;
        while (!ch0_rd && n < 100) begin
            @(negedge gmii_tx_clk);
            n++;
        end
        check("ch0 rd seen before timeout", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge gmii_tx_clk);
        check("txen before mid-frame reset", 32'(gmii_txen), 32'd1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid-frame reset outputs {txen,txer,grant,busy,rd}",
              32'({gmii_txen, gmii_txer, grant, busy, ch0_rd, ch1_rd}), 32'd0);
        repeat (2) @(posedge gmii_tx_clk);
        #2;
        exp_frame(0, -2, 1);
        arm(0); drive_src();
        rst_n = 1'b1;
        wait_idle();

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
